// File: rtl/multicycle_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm_if
//   Bundles the signals between the multicycle control sequencer and the
//   datapath / memory handshake.
//
//   Signal prefixes are relative to the controller: i_* go into it, o_* come
//   out of it.
//     i_opcode       [3:0]        IR[15:12], valid from DECODE onward
//     i_zero                      ALU zero flag, sampled in EXEC
//     i_mem_ready                 memory completes access this cycle
//     o_sel_a        [3:0]        one-hot PC/ALU-A source select
//     o_sel_b        [2:0]        one-hot ALU-B source select
//     o_sel_c        [5:0]        one-hot writeback source select
//     o_pc_write, o_ir_write, o_reg_write, o_mem_read, o_mem_write
//                                 datapath strobes
//     o_retire                    1-cycle pulse in the last cycle of an instruction
//     o_retire_count [RCNT_W-1:0] retired-instruction count (wraps)
//     o_fault                     1-cycle pulse on memory timeout / trap
//     o_halted                    high while halted
//
//   Modports: master = the controller, slave = the datapath side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_fsm_if #(
    parameter int RCNT_W = 16
);
    logic [3:0]        i_opcode;
    logic              i_zero;
    logic              i_mem_ready;
    logic [3:0]        o_sel_a;
    logic [2:0]        o_sel_b;
    logic [5:0]        o_sel_c;
    logic              o_pc_write;
    logic              o_ir_write;
    logic              o_reg_write;
    logic              o_mem_read;
    logic              o_mem_write;
    logic              o_retire;
    logic [RCNT_W-1:0] o_retire_count;
    logic              o_fault;
    logic              o_halted;

    modport master (
        input  i_opcode, i_zero, i_mem_ready,
        output o_sel_a, o_sel_b, o_sel_c,
        output o_pc_write, o_ir_write, o_reg_write, o_mem_read, o_mem_write,
        output o_retire, o_retire_count, o_fault, o_halted
    );

    modport slave (
        output i_opcode, i_zero, i_mem_ready,
        input  o_sel_a, o_sel_b, o_sel_c,
        input  o_pc_write, o_ir_write, o_reg_write, o_mem_read, o_mem_write,
        input  o_retire, o_retire_count, o_fault, o_halted
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//   Multicycle control sequencer. Steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB and drives the one-hot mux selects and
//   datapath strobes. Memory waits in FETCH and MEM are bounded by STALL_MAX;
//   on timeout a Fault pulse is issued and the sequencer restarts in FETCH.
//
// Parameters
//   STALL_MAX  wait cycles tolerated with MemReady low before abort (1..255)
//   RCNT_W     width of the retired-instruction counter
//
// Ports
//   i_clk      clock, all state updates on the rising edge
//   i_rst      synchronous active-high reset; forces every output to 0
//   bus        multicycle_ctrl_fsm_if.master (opcode/zero/mem_ready in,
//              selects, strobes, retire/count, fault, halted out)
//
// Build option
//   ILLEGAL_OP_TRAP_EN  defined: illegal opcodes go DECODE -> TRAP (Fault
//                       pulse) -> HALT. Undefined: illegal opcodes behave as
//                       NOP and TRAP is unreachable.
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
    parameter int STALL_MAX = 15,
    parameter int RCNT_W    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    multicycle_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ALUR  = 4'h1;
    localparam logic [3:0] OP_ALUI  = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_BEQ   = 4'h5;
    localparam logic [3:0] OP_JUMP  = 4'h6;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [7:0] STALL_LIMIT = 8'(STALL_MAX);

    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_JUMP) || (op == OP_HALT);
    endfunction

    // Registers
    state_t            r_state;
    logic [3:0]        r_op;
    logic [7:0]        r_wait;
    logic [RCNT_W-1:0] r_count;

    // Next-state / decoded outputs
    state_t            w_state_next;
    logic              w_stall;
    logic              w_timeout;
    logic [3:0]        w_sel_a;
    logic [2:0]        w_sel_b;
    logic [5:0]        w_sel_c;
    logic              w_pc_write;
    logic              w_ir_write;
    logic              w_reg_write;
    logic              w_mem_read;
    logic              w_mem_write;
    logic              w_retire;
    logic              w_fault;
    logic              w_halted;

    // r_wait holds the number of stall cycles already spent in this state,
    // so the abort happens on the cycle after STALL_MAX stalls if MemReady
    // is still low.
    assign w_timeout = (r_wait == STALL_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_op    <= OP_NOP;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_stall ? r_wait + 8'd1 : 8'd0;
            if (r_state == S_DECODE) begin
                r_op <= bus.i_opcode;
            end
            if (w_retire) begin
                r_count <= r_count + RCNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_sel_a      = '0;
        w_sel_b      = '0;
        w_sel_c      = '0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_retire     = 1'b0;
        w_fault      = 1'b0;
        w_halted     = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                w_sel_a    = 4'b0001;
                if (bus.i_mem_ready) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_fault      = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_stall = 1'b1;
                end
            end

            S_DECODE: begin
                // Branch target is precomputed here regardless of opcode.
                w_sel_a = 4'b0010;
                if (bus.i_opcode == OP_HALT) begin
                    w_state_next = S_HALT;
                end else if (!op_is_legal(bus.i_opcode)) begin
`ifdef ILLEGAL_OP_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    w_state_next = S_EXEC;
`endif
                end else begin
                    w_state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                case (r_op)
                    OP_ALUR: begin
                        w_sel_b      = 3'b001;
                        w_state_next = S_WB;
                    end
                    OP_ALUI: begin
                        w_sel_b      = 3'b010;
                        w_state_next = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_sel_b      = 3'b010;
                        w_state_next = S_MEM;
                    end
                    OP_BEQ: begin
                        w_sel_b      = 3'b001;
                        w_sel_a      = 4'b0100;
                        w_pc_write   = bus.i_zero;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    OP_JUMP: begin
                        w_sel_a      = 4'b1000;
                        w_pc_write   = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                    default: begin
                        // NOP, and illegal opcodes when trapping is off.
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                w_mem_read  = (r_op == OP_LOAD);
                w_mem_write = (r_op != OP_LOAD);
                if (bus.i_mem_ready) begin
                    if (r_op == OP_LOAD) begin
                        w_state_next = S_WB;
                    end else begin
                        w_retire     = 1'b1;
                        w_state_next = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_fault      = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    w_stall = 1'b1;
                end
            end

            S_WB: begin
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_sel_c      = (r_op == OP_LOAD) ? 6'b100000 : 6'b000001;
                w_state_next = S_FETCH;
            end

            S_TRAP: begin
                w_fault      = 1'b1;
                w_state_next = S_HALT;
            end

            S_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every output so an instruction interrupted mid-flight
    // cannot leave a partial write on the datapath.
    assign bus.o_sel_a        = i_rst ? 4'b0 : w_sel_a;
    assign bus.o_sel_b        = i_rst ? 3'b0 : w_sel_b;
    assign bus.o_sel_c        = i_rst ? 6'b0 : w_sel_c;
    assign bus.o_pc_write     = ~i_rst & w_pc_write;
    assign bus.o_ir_write     = ~i_rst & w_ir_write;
    assign bus.o_reg_write    = ~i_rst & w_reg_write;
    assign bus.o_mem_read     = ~i_rst & w_mem_read;
    assign bus.o_mem_write    = ~i_rst & w_mem_write;
    assign bus.o_retire       = ~i_rst & w_retire;
    assign bus.o_fault        = ~i_rst & w_fault;
    assign bus.o_halted       = ~i_rst & w_halted;
    assign bus.o_retire_count = i_rst ? '0 : r_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//   Directed bench. Each stimulus cycle pushes the hand-computed expected
//   output vector into a queue; a monitor pops one entry per cycle at the
//   falling edge and compares it with the DUT outputs.
//   A second instance with a 4-bit retire counter runs in lockstep so the
//   counter wrap (all-ones -> 0) is reached in a short run.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int STALL_MAX = 15;

    // Strobe byte layout: {PCW, IRW, RW, MRD, MWR, RET, FLT, HLT}
    localparam logic [7:0] PCW = 8'h80;
    localparam logic [7:0] IRW = 8'h40;
    localparam logic [7:0] RW  = 8'h20;
    localparam logic [7:0] MRD = 8'h10;
    localparam logic [7:0] MWR = 8'h08;
    localparam logic [7:0] RET = 8'h04;
    localparam logic [7:0] FLT = 8'h02;
    localparam logic [7:0] HLT = 8'h01;

    typedef struct packed {
        logic [3:0]  a;
        logic [2:0]  b;
        logic [5:0]  c;
        logic [7:0]  s;
        logic [15:0] cnt;
        logic [3:0]  cnt_w;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.RCNT_W(16)) bus ();
    multicycle_ctrl_fsm_if #(.RCNT_W(4))  bus_w ();

    assign bus_w.i_opcode    = bus.i_opcode;
    assign bus_w.i_zero      = bus.i_zero;
    assign bus_w.i_mem_ready = bus.i_mem_ready;

    multicycle_ctrl_fsm #(.STALL_MAX(STALL_MAX), .RCNT_W(16)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    multicycle_ctrl_fsm #(.STALL_MAX(STALL_MAX), .RCNT_W(4)) dut_w (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_w)
    );

    exp_t        exp_q[$];
    string       lbl_q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    // ---------------- monitor ----------------
    exp_t  mon_e;
    exp_t  mon_g;
    string mon_l;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                mon_l = lbl_q.pop_front();
                mon_g.a     = bus.o_sel_a;
                mon_g.b     = bus.o_sel_b;
                mon_g.c     = bus.o_sel_c;
                mon_g.s     = {bus.o_pc_write, bus.o_ir_write, bus.o_reg_write,
                               bus.o_mem_read, bus.o_mem_write, bus.o_retire,
                               bus.o_fault, bus.o_halted};
                mon_g.cnt   = bus.o_retire_count;
                mon_g.cnt_w = bus_w.o_retire_count;
                n_vec++;
                if (mon_g !== mon_e) begin
                    n_bad++;
                    $display("FAIL %s: got a=%b b=%b c=%b s=%b cnt=%h cw=%h, want a=%b b=%b c=%b s=%b cnt=%h cw=%h",
                             mon_l, mon_g.a, mon_g.b, mon_g.c, mon_g.s, mon_g.cnt, mon_g.cnt_w,
                             mon_e.a, mon_e.b, mon_e.c, mon_e.s, mon_e.cnt, mon_e.cnt_w);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input string lbl, input logic [3:0] op, input logic z,
                        input logic mr, input logic [3:0] a, input logic [2:0] b,
                        input logic [5:0] c, input logic [7:0] s);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.i_opcode    = op;
        bus.i_zero      = z;
        bus.i_mem_ready = mr;
        e.a     = a;
        e.b     = b;
        e.c     = c;
        e.s     = s;
        e.cnt   = exp_cnt;
        e.cnt_w = exp_cnt[3:0];
        exp_q.push_back(e);
        lbl_q.push_back(lbl);
        if ((s & RET) != 8'h00) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic do_reset(input int n, input logic mr);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst             = 1'b1;
            bus.i_mem_ready = mr;
            e       = '0;
            exp_q.push_back(e);
            lbl_q.push_back("reset");
        end
        exp_cnt = 16'd0;
    endtask

    task automatic fetch_ok(input string n, input logic [3:0] op);
        step({n, " FETCH"}, op, 1'b0, 1'b1, 4'b0001, 3'b000, 6'b0, PCW | IRW | MRD);
    endtask

    task automatic decode(input string n, input logic [3:0] op);
        step({n, " DECODE"}, op, 1'b0, 1'b1, 4'b0010, 3'b000, 6'b0, 8'h00);
    endtask

    task automatic run_alu(input string n, input logic [3:0] op, input logic [2:0] selb);
        $display("[%0t] issue %s", $time, n);
        fetch_ok(n, op);
        decode(n, op);
        step({n, " EXEC"}, op, 1'b0, 1'b1, 4'b0000, selb, 6'b0, 8'h00);
        step({n, " WB"}, op, 1'b0, 1'b1, 4'b0000, 3'b000, 6'b000001, RW | RET);
    endtask

    task automatic run_load(input int delay);
        $display("[%0t] issue LOAD delay=%0d", $time, delay);
        fetch_ok("LOAD", 4'h3);
        decode("LOAD", 4'h3);
        step("LOAD EXEC", 4'h3, 1'b0, 1'b1, 4'b0000, 3'b010, 6'b0, 8'h00);
        for (int i = 0; i < delay; i++)
            step("LOAD MEMWAIT", 4'h3, 1'b0, 1'b0, 4'b0000, 3'b000, 6'b0, MRD);
        step("LOAD MEM", 4'h3, 1'b0, 1'b1, 4'b0000, 3'b000, 6'b0, MRD);
        step("LOAD WB", 4'h3, 1'b0, 1'b1, 4'b0000, 3'b000, 6'b100000, RW | RET);
    endtask

    task automatic run_store_head();
        fetch_ok("STORE", 4'h4);
        decode("STORE", 4'h4);
        step("STORE EXEC", 4'h4, 1'b0, 1'b1, 4'b0000, 3'b010, 6'b0, 8'h00);
    endtask

    task automatic run_beq(input logic z);
        $display("[%0t] issue BEQ zero=%0b", $time, z);
        fetch_ok("BEQ", 4'h5);
        decode("BEQ", 4'h5);
        step("BEQ EXEC", 4'h5, z, 1'b1, 4'b0100, 3'b001, 6'b0, (z ? PCW : 8'h00) | RET);
    endtask

    task automatic run_simple(input string n, input logic [3:0] op,
                              input logic [3:0] a, input logic [7:0] s);
        $display("[%0t] issue %s op=%h", $time, n, op);
        fetch_ok(n, op);
        decode(n, op);
        step({n, " EXEC"}, op, 1'b0, 1'b1, a, 3'b000, 6'b0, s);
    endtask

    task automatic stall_fetch(input int n);
        for (int i = 0; i < n; i++)
            step("FETCH stall", 4'h0, 1'b0, 1'b0, 4'b0001, 3'b000, 6'b0, MRD);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want finish before 200000");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.i_opcode    = 4'h0;
        bus.i_zero      = 1'b0;
        bus.i_mem_ready = 1'b0;

        do_reset(2, 1'b1);

        run_alu("ALU-R", 4'h1, 3'b001);
        run_alu("ALU-I", 4'h2, 3'b010);
        run_load(3);

        $display("[%0t] issue STORE", $time);
        run_store_head();
        step("STORE MEM", 4'h4, 1'b0, 1'b1, 4'b0000, 3'b000, 6'b0, MWR | RET);

        run_beq(1'b0);
        run_beq(1'b1);
        run_simple("JUMP", 4'h6, 4'b1000, PCW | RET);
        run_simple("NOP", 4'h0, 4'b0000, RET);

        // Fetch timeout: STALL_MAX stall cycles, then the Fault cycle.
        $display("[%0t] issue FETCH timeout", $time);
        stall_fetch(STALL_MAX);
        step("FETCH fault", 4'h0, 1'b0, 1'b0, 4'b0001, 3'b000, 6'b0, MRD | FLT);
        // Counter restarted: a few more stalls produce no fault.
        stall_fetch(3);
        run_simple("NOP", 4'h0, 4'b0000, RET);

        // MemReady on the would-be fault cycle wins.
        $display("[%0t] issue FETCH late ready", $time);
        stall_fetch(STALL_MAX);
        run_simple("NOP", 4'h0, 4'b0000, RET);

        // Store that times out in MEM: no retire, back to FETCH.
        $display("[%0t] issue STORE timeout", $time);
        run_store_head();
        for (int i = 0; i < STALL_MAX; i++)
            step("STORE MEMWAIT", 4'h4, 1'b0, 1'b0, 4'b0000, 3'b000, 6'b0, MWR);
        step("STORE fault", 4'h4, 1'b0, 1'b0, 4'b0000, 3'b000, 6'b0, MWR | FLT);
        run_simple("NOP", 4'h0, 4'b0000, RET);

        // Reset held 3 cycles in the middle of a STORE's MEM phase.
        $display("[%0t] issue STORE reset", $time);
        run_store_head();
        step("STORE MEMWAIT", 4'h4, 1'b0, 1'b0, 4'b0000, 3'b000, 6'b0, MWR);
        do_reset(3, 1'b1);
        run_simple("NOP", 4'h0, 4'b0000, RET);

        // Retire-count wrap on the narrow instance (15 -> 0).
        for (int i = 0; i < 17; i++)
            run_simple("NOP", 4'h0, 4'b0000, RET);

        // Illegal opcode 7.
`ifdef ILLEGAL_OP_TRAP_EN
        $display("[%0t] issue ILLEGAL trap", $time);
        fetch_ok("ILL", 4'h7);
        decode("ILL", 4'h7);
        step("ILL TRAP", 4'h7, 1'b0, 1'b1, 4'b0000, 3'b000, 6'b0, FLT);
        for (int i = 0; i < 4; i++)
            step("ILL HALT", 4'h0, 1'b0, 1'b1, 4'b0000, 3'b000, 6'b0, HLT);
        do_reset(1, 1'b0);
        run_simple("NOP", 4'h0, 4'b0000, RET);
`else
        run_simple("ILL", 4'h7, 4'b0000, RET);
        run_simple("ILL", 4'hA, 4'b0000, RET);
`endif

        // HALT is sticky until reset.
        $display("[%0t] issue HALT", $time);
        fetch_ok("HALT", 4'hF);
        decode("HALT", 4'hF);
        for (int i = 0; i < 3; i++)
            step("HALTED", 4'h1, 1'b1, 1'b1, 4'b0000, 3'b000, 6'b0, HLT);
        do_reset(1, 1'b1);
        run_alu("ALU-R", 4'h1, 3'b001);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
